// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//   SPI master that originates the 10-bit command frames consumed by the
//   SPI slave/RAM wrapper. One host command is taken per valid/ready
//   handshake. The frame {cmd_op, cmd_payload} is shifted out MSB first on
//   MOSI, after a leading bit that repeats cmd_op[1] (the slave's read/write
//   decision bit). For op 11 (read-data) the block then waits RD_WAIT cycles
//   and deserializes 8 bits from MISO into rd_data.
//
// Ports
//   clk          system clock, rising edge
//   arst_n       synchronous active-low reset
//   cmd_valid    host command valid
//   cmd_ready    high only in IDLE and out of reset
//   cmd_op       00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//   cmd_payload  address or write data (still shifted out for op 11)
//   busy         high from acceptance until the end of the inter-frame gap
//   rd_data      last captured read byte
//   rd_valid     one-cycle pulse when rd_data updates
//   SS_n         slave select, active-low
//   MOSI         serial data to slave
//   MISO         serial data from slave
//
// Parameters
//   RD_WAIT         turnaround cycles before the first MISO sample (1..7)
//   GAP             minimum SS_n-high cycles between frames (1..15)
//   MISO_LSB_FIRST  1: first sampled bit lands in rd_data[0]; 0: in rd_data[7]

module spi_master_ctrl #(
  parameter int unsigned RD_WAIT        = 2,
  parameter int unsigned GAP            = 3,
  parameter bit          MISO_LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_payload,
  output logic       busy,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CMD,
    ST_SHIFT,
    ST_WAIT,
    ST_RECV,
    ST_HOLD,
    ST_GAP
  } state_e;

  localparam logic [2:0] WAIT_LAST = 3'(RD_WAIT - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

  state_e     state_q, state_d;
  logic [9:0] frame_q, frame_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] wr_cnt_q, wr_cnt_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic [3:0] shift_idx;
  logic       is_read;

  assign is_read   = (frame_q[9:8] == 2'b11);
  // Index of the frame bit that goes out in the cycle after the current
  // SHIFT cycle; only used while bit_cnt_q is 0..8.
  assign shift_idx = 4'd8 - bit_cnt_q;

  assign cmd_ready = (state_q == ST_IDLE) & arst_n;
  assign busy      = busy_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;

  // Next-state logic. All serial outputs are registered, so each branch
  // computes the value the pins take in the *next* cycle.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    shreg_d    = shreg_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ss_n_d     = ss_n_q;
    mosi_d     = 1'b0;
    busy_d     = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          frame_d = {cmd_op, cmd_payload};
          state_d = ST_START;
          ss_n_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      // The leading command bit repeats the op's read/write bit.
      ST_START: begin
        state_d = ST_CMD;
        mosi_d  = frame_q[9];
      end

      ST_CMD: begin
        state_d   = ST_SHIFT;
        bit_cnt_d = 4'd0;
        mosi_d    = frame_q[9];
      end

      ST_SHIFT: begin
        if (bit_cnt_q == 4'd9) begin
          if (is_read) begin
            state_d  = ST_WAIT;
            wr_cnt_d = 3'd0;
          end else begin
            state_d = ST_HOLD;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          mosi_d    = frame_q[shift_idx];
        end
      end

      ST_WAIT: begin
        if (wr_cnt_q == WAIT_LAST) begin
          state_d  = ST_RECV;
          wr_cnt_d = 3'd0;
        end else begin
          wr_cnt_d = wr_cnt_q + 3'd1;
        end
      end

      // One MISO sample per RECV cycle, taken on the edge closing it.
      ST_RECV: begin
        if (MISO_LSB_FIRST) begin
          shreg_d = {MISO, shreg_q[7:1]};
        end else begin
          shreg_d = {shreg_q[6:0], MISO};
        end
        if (wr_cnt_q == 3'd7) begin
          state_d  = ST_HOLD;
          wr_cnt_d = 3'd0;
        end else begin
          wr_cnt_d = wr_cnt_q + 3'd1;
        end
      end

      // Leaving HOLD releases SS_n and, for reads, publishes the byte.
      ST_HOLD: begin
        state_d   = ST_GAP;
        ss_n_d    = 1'b1;
        gap_cnt_d = 4'd0;
        if (is_read) begin
          rd_data_d  = shreg_q;
          rd_valid_d = 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ss_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      shreg_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      shreg_q    <= shreg_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
    end
  end

endmodule
